// File: rtl/serial_reduce_pkg.sv
// Shared types and helpers for the serial reduction receiver.
package serial_reduce_pkg;

  // Output slot occupancy.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Returns {and, or, xor} over the low 'width' bits of 'word'.
  function automatic logic [2:0] reduce3(input logic [63:0] word, input int width);
    logic r_and;
    logic r_or;
    logic r_xor;
    r_and = 1'b1;
    r_or  = 1'b0;
    r_xor = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i < width) begin
        r_and = r_and & word[i];
        r_or  = r_or  | word[i];
        r_xor = r_xor ^ word[i];
      end
    end
    return {r_and, r_or, r_xor};
  endfunction

endpackage

// File: rtl/serial_reduce_rx_shift_collect.sv
// Partial-word shift register and bit counter. 'full_word' is the word as it
// would look with the current bit included; 'complete' flags the last beat.
module shift_collect #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     beat,
  input  logic                     bit_in,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     complete,
  output logic [WIDTH-1:0]         full_word
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;

  // Shift direction decides where the first received bit ends up.
  always_comb begin
    if (MSB_FIRST) full_word = {shreg_q[WIDTH-2:0], bit_in};
    else           full_word = {bit_in, shreg_q[WIDTH-1:1]};
    complete = beat && (cnt_q == CW'(WIDTH - 1));
  end

  // Shift on every beat; clear aborts the partial word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (beat) begin
      shreg_q <= full_word;
      cnt_q   <= complete ? '0 : cnt_q + CW'(1);
    end
  end

  assign bit_cnt = cnt_q;

endmodule

// File: rtl/serial_reduce_rx.sv
// Serial-to-parallel receiver: collects WIDTH bits, then presents the word and
// its AND/OR/XOR reductions on a one-entry registered output slot.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and the payload holds while valid && !ready.
module serial_reduce_rx import serial_reduce_pkg::*; #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     s_bit,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_word,
  output logic                     m_and,
  output logic                     m_or,
  output logic                     m_xor,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH);

  slot_state_t      state_q;
  slot_state_t      state_d;
  logic             beat;
  logic             complete;
  logic             last_bit;
  logic [WIDTH-1:0] full_word;
  logic [2:0]       red;

  // Only the completing bit stalls, and only when the slot cannot free up now.
  always_comb begin
    last_bit = (bit_cnt == CW'(WIDTH - 1));
    s_ready  = !clear && !(last_bit && m_valid && !m_ready);
    beat     = s_valid && s_ready;
    red      = reduce3(64'(full_word), WIDTH);
  end

  shift_collect #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_collect (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .beat      (beat),
    .bit_in    (s_bit),
    .bit_cnt   (bit_cnt),
    .complete  (complete),
    .full_word (full_word)
  );

  // Slot state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= SLOT_EMPTY;
    else          state_q <= state_d;
  end

  // Next slot state: a completing beat always fills; a drain alone empties.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (complete) state_d = SLOT_FULL;
      SLOT_FULL:  if (!complete && m_ready) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  // Slot occupancy drives the output valid.
  always_comb begin
    m_valid = (state_q == SLOT_FULL);
  end

  // Word and reductions load together on the completing beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_word <= '0;
      m_and  <= 1'b0;
      m_or   <= 1'b0;
      m_xor  <= 1'b0;
    end else if (complete) begin
      m_word <= full_word;
      m_and  <= red[2];
      m_or   <= red[1];
      m_xor  <= red[0];
    end
  end

endmodule

// File: tb/tb_serial_reduce_rx.sv
// Bench for serial_reduce_rx: an LSB-first and an MSB-first instance share
// the same input stream; each has its own expected queue and monitor.
module tb_serial_reduce_rx;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  logic s_valid = 1'b0;
  logic s_bit = 1'b0;
  logic m_ready = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic         s_ready0, m_valid0, m_and0, m_or0, m_xor0;
  logic [W-1:0] m_word0;
  logic [2:0]   bit_cnt0;
  logic         s_ready1, m_valid1, m_and1, m_or1, m_xor1;
  logic [W-1:0] m_word1;
  logic [2:0]   bit_cnt1;

  serial_reduce_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .s_valid(s_valid),
    .s_ready(s_ready0), .s_bit(s_bit), .m_valid(m_valid0), .m_ready(m_ready),
    .m_word(m_word0), .m_and(m_and0), .m_or(m_or0), .m_xor(m_xor0),
    .bit_cnt(bit_cnt0)
  );

  serial_reduce_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset_n(reset_n), .clear(clear), .s_valid(s_valid),
    .s_ready(s_ready1), .s_bit(s_bit), .m_valid(m_valid1), .m_ready(m_ready),
    .m_word(m_word1), .m_and(m_and1), .m_or(m_or1), .m_xor(m_xor1),
    .bit_cnt(bit_cnt1)
  );

  // ---------------- scoreboard ----------------
  int             n_cmp = 0;
  int             n_err = 0;
  logic [W+2:0]   exp_q0[$];
  logic [W+2:0]   exp_q1[$];
  logic [W+2:0]   e0, e1;
  logic [W-1:0]   col_w = '0;
  int             col_n = 0;
  bit             stream_mode = 1'b0;
  bit             have_prev = 1'b0;
  int             prev_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W+2:0] pack_exp(input logic [W-1:0] w);
    return {w, &w, |w, ^w};
  endfunction

  function automatic logic [W-1:0] rev(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[W-1-i] = w[i];
    return r;
  endfunction

  // Model: the i-th accepted bit of a word is bit i LSB-first, bit W-1-i MSB-first.
  task automatic record_bit(input logic b);
    col_w[col_n] = b;
    col_n++;
    if (col_n == W) begin
      exp_q0.push_back(pack_exp(col_w));
      exp_q1.push_back(pack_exp(rev(col_w)));
      col_n = 0;
      col_w = '0;
    end
  endtask

  // Monitor for the LSB-first instance, plus word spacing in streaming mode.
  always @(negedge clk) begin
    if (reset_n && m_valid0 && m_ready) begin
      if (exp_q0.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL lsb_unexpected_word: got %0h, expected no word", m_word0);
      end else begin
        e0 = exp_q0.pop_front();
        check("lsb_word_red", {m_word0, m_and0, m_or0, m_xor0}, e0);
      end
      if (stream_mode) begin
        if (have_prev) check("stream_gap", cyc - prev_cyc, W);
        prev_cyc  = cyc;
        have_prev = 1'b1;
      end
    end
  end

  // Monitor for the MSB-first instance.
  always @(negedge clk) begin
    if (reset_n && m_valid1 && m_ready) begin
      if (exp_q1.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL msb_unexpected_word: got %0h, expected no word", m_word1);
      end else begin
        e1 = exp_q1.pop_front();
        check("msb_word_red", {m_word1, m_and1, m_or1, m_xor1}, e1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    int waited;
    waited = 0;
    s_valid = 1'b1;
    s_bit   = b;
    @(negedge clk);
    while (!s_ready0 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!s_ready0) begin
      n_cmp++;
      n_err++;
      $display("FAIL s_ready_timeout: got s_ready=0 for 50 cycles, expected 1");
    end else begin
      @(posedge clk);
      #1;
      record_bit(b);
    end
  endtask

  task automatic send_bits(input logic [W-1:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] v;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid0, 0);
    check("rst_m_word", m_word0, 0);
    check("rst_reductions", {m_and0, m_or0, m_xor0}, 0);
    check("rst_bit_cnt", bit_cnt0, 0);
    check("rst_msb_m_valid", m_valid1, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_s_ready", s_ready0, 1);
    @(posedge clk);
    #1;
    m_ready = 1'b1;

    // All-ones word, with first-word latency.
    send_bits(8'hFF, 7);
    check("ff_not_yet_valid", m_valid0, 0);
    check("ff_bit_cnt7", bit_cnt0, 7);
    send_bit(1'b1);
    check("ff_valid_after_8", m_valid0, 1);
    check("ff_word", m_word0, 8'hFF);
    check("ff_red", {m_and0, m_or0, m_xor0}, 3'b110);
    check("ff_bit_cnt_wrap", bit_cnt0, 0);
    idle(3);

    // Palindrome A5, then 0x01 (MSB-first lands as 0x80).
    send_bits(8'hA5, 8);
    check("a5_word", m_word0, 8'hA5);
    check("a5_msb_word", m_word1, 8'hA5);
    send_bits(8'h01, 8);
    check("01_word", m_word0, 8'h01);
    check("01_msb_word", m_word1, 8'h80);
    check("01_msb_xor", m_xor1, 1);
    idle(3);

    // Hold: 0x00 sits unread while 7 more bits are collected.
    m_ready = 1'b0;
    send_bits(8'h00, 8);
    v = 8'h3C;
    send_bits(v, 7);
    s_bit = v[7];
    check("hold_bit_cnt", bit_cnt0, 7);
    check("hold_s_ready", s_ready0, 0);
    check("hold_m_valid", m_valid0, 1);
    check("hold_m_word", m_word0, 8'h00);
    check("hold_red", {m_and0, m_or0, m_xor0}, 3'b000);
    repeat (2) begin
      @(negedge clk);
      check("hold_stall", s_ready0, 0);
      check("hold_word_stable", m_word0, 8'h00);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    send_bit(v[7]);
    check("b2b_m_valid", m_valid0, 1);
    check("b2b_m_word", m_word0, 8'h3C);
    check("b2b_bit_cnt", bit_cnt0, 0);
    idle(3);

    // Clear mid-word drops the bit offered in the clear cycle.
    send_bits(8'h05, 3);
    s_bit = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    check("clear_s_ready", s_ready0, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear_bit_cnt", bit_cnt0, 0);
    check("clear_msb_bit_cnt", bit_cnt1, 0);
    col_n = 0;
    col_w = '0;
    send_bits(8'h6B, 8);
    check("after_clear_word", m_word0, 8'h6B);
    check("after_clear_msb_word", m_word1, 8'hD6);
    idle(3);

    // Continuous stream of four words.
    stream_mode = 1'b1;
    have_prev   = 1'b0;
    send_bits(8'h12, 8);
    send_bits(8'h34, 8);
    send_bits(8'h7F, 8);
    send_bits(8'hC8, 8);
    idle(3);
    stream_mode = 1'b0;

    // Asynchronous reset while a word is held and another is partly collected.
    m_ready = 1'b0;
    send_bits(8'h96, 8);
    send_bits(8'h07, 3);
    check("pre_rst_m_valid", m_valid0, 1);
    check("pre_rst_bit_cnt", bit_cnt0, 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_m_valid", m_valid0, 0);
    check("async_rst_bit_cnt", bit_cnt0, 0);
    check("async_rst_m_word", m_word0, 0);
    check("async_rst_msb_m_valid", m_valid1, 0);
    exp_q0.delete();
    exp_q1.delete();
    col_n = 0;
    col_w = '0;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_ready = 1'b1;
    idle(4);
    check("post_rst_m_valid", m_valid0, 0);

    // Drain anything outstanding, bounded.
    for (int i = 0; i < 20 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++) @(posedge clk);
    check("lsb_queue_empty", exp_q0.size(), 0);
    check("msb_queue_empty", exp_q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
